// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional IF_PERF_CNT_EN build adds fetch/bubble performance counters to if_fetch_unit.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_C      = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INCR          = 32'd4;

   // Force a target address onto a 32-bit instruction boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_unit_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface

// File: rtl/if_hold_buffer.sv
// Holds an instruction returned while IF/ID was stalled; async clear on
// rst_n, synchronous clear on srst (wins over load).
module if_hold_buffer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        srst,
   input  logic        load,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] data_r;

   // Buffered-instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= 32'h0000_0000;
      end else if (srst) begin
         data_r <= 32'h0000_0000;
      end else if (load) begin
         data_r <= d;
      end
   end

   assign q = data_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem fetch, stall hold buffer, EX redirects.
// Define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_bubble_cnt outputs.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [31:0]            redirect_pc,
   if_fetch_unit_if.master        imem,
   output logic [31:0]            pc_out,
   output logic [31:0]            instr_out,
   output logic                   valid_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetch_cnt,
   output logic [31:0]            perf_bubble_cnt
`endif
);

   fetch_state_e state_r;
   logic [31:0]  pc_r;
   logic [31:0]  hold_data_s;
   logic         hold_load_s;
   logic         valid_s;
   logic [31:0]  instr_s;
   logic         req_valid_s;

   // Stall-capture buffer; any redirect throws its contents away
   if_hold_buffer u_hold_buffer (
      .clk   (clk),
      .rst_n (rst),
      .srst  (redirect_valid),
      .load  (hold_load_s),
      .d     (imem.imem_resp_data),
      .q     (hold_data_s)
   );

   // Fetch FSM and architectural PC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_REQ;
         pc_r    <= RESET_PC;
      end else if (redirect_valid) begin
         pc_r <= word_align(redirect_pc);
         case (state_r)
            // The outstanding response may land in the redirect cycle itself;
            // only keep dropping while it is still in flight.
            ST_WAIT: state_r <= imem.imem_resp_valid ? ST_REQ : ST_DROP;
            ST_DROP: state_r <= imem.imem_resp_valid ? ST_REQ : ST_DROP;
            default: state_r <= ST_REQ;
         endcase
      end else begin
         case (state_r)
            ST_REQ: begin
               if (imem.imem_req_ready) state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem.imem_resp_valid && !stall) begin
                  pc_r    <= pc_r + PC_INCR;
                  state_r <= ST_REQ;
               end else if (imem.imem_resp_valid) begin
                  state_r <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc_r    <= pc_r + PC_INCR;
                  state_r <= ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem.imem_resp_valid) state_r <= ST_REQ;
            end
            default: state_r <= ST_REQ;
         endcase
      end
   end

   // Presentation to IF/ID and imem request, all suppressed in reset and redirect cycles
   always_comb begin
      valid_s     = 1'b0;
      instr_s     = NOP_INSTR;
      req_valid_s = 1'b0;
      hold_load_s = 1'b0;
      if (!rst || redirect_valid) begin
         valid_s = 1'b0;
      end else begin
         case (state_r)
            ST_REQ:  req_valid_s = 1'b1;
            ST_WAIT: begin
               if (imem.imem_resp_valid && !stall) begin
                  valid_s = 1'b1;
                  instr_s = imem.imem_resp_data;
               end else begin
                  hold_load_s = imem.imem_resp_valid;
               end
            end
            ST_HOLD: begin
               valid_s = 1'b1;
               instr_s = hold_data_s;
            end
            default: valid_s = 1'b0;
         endcase
      end
   end

   assign valid_out           = valid_s;
   assign instr_out           = instr_s;
   assign pc_out              = pc_r;
   assign imem.imem_req_valid = req_valid_s;
   assign imem.imem_req_addr  = pc_r;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_r;
   logic [31:0] bubble_cnt_r;

   // Delivered-instruction and bubble counters, free-running with wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_r  <= 32'h0000_0000;
         bubble_cnt_r <= 32'h0000_0000;
      end else begin
         if (valid_s && !stall) fetch_cnt_r <= fetch_cnt_r + 32'd1;
         if (!valid_s) bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt_r;
   assign perf_bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; perf counter checks are
// compiled in when IF_PERF_CNT_EN is defined.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        valid_out;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   int total = 0;
   int bad   = 0;

   if_fetch_unit_if imem_bus ();

   if_fetch_unit dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem            (imem_bus),
      .pc_out          (pc_out),
      .instr_out       (instr_out),
      .valid_out       (valid_out)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus, applied just after the rising edge
   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic stl, input logic rdv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      imem_bus.imem_req_ready  = rdy;
      imem_bus.imem_resp_valid = rv;
      imem_bus.imem_resp_data  = rd;
      stall                    = stl;
      redirect_valid           = rdv;
      redirect_pc              = rpc;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                             input logic [31:0] ins, input logic rq, input logic [31:0] ra);
      check_val({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
      check_val({tag, ".pc"}, pc_out, pc);
      check_val({tag, ".instr"}, instr_out, ins);
      check_val({tag, ".reqv"}, {31'd0, imem_bus.imem_req_valid}, {31'd0, rq});
      if (rq) check_val({tag, ".addr"}, imem_bus.imem_req_addr, ra);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst                      = 1'b0;
      stall                    = 1'b0;
      redirect_valid           = 1'b0;
      redirect_pc              = 32'h0;
      imem_bus.imem_req_ready  = 1'b0;
      imem_bus.imem_resp_valid = 1'b0;
      imem_bus.imem_resp_data  = 32'h0;
      #12;
      expect_out("reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0);

      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      expect_out("rel", 1'b0, 32'h0, NOP, 1'b1, 32'h0);

      // Sequential fetch, 1-cycle response latency
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("f0q", 1'b0, 32'h0, NOP, 1'b1, 32'h0);
      drive(1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0);
      expect_out("f0r", 1'b1, 32'h0, 32'h1111_0000, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("f4q", 1'b0, 32'h4, NOP, 1'b1, 32'h4);
      drive(1'b0, 1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'h0);
      expect_out("f4r", 1'b1, 32'h4, 32'h1111_0004, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("f8q", 1'b0, 32'h8, NOP, 1'b1, 32'h8);

      // Response at pc 8 under a 3-cycle stall
      drive(1'b0, 1'b1, 32'h1111_0008, 1'b1, 1'b0, 32'h0);
      check_val("st0.reqv", {31'd0, imem_bus.imem_req_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      expect_out("st1", 1'b1, 32'h8, 32'h1111_0008, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      expect_out("st2", 1'b1, 32'h8, 32'h1111_0008, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("st3", 1'b1, 32'h8, 32'h1111_0008, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("f12q", 1'b0, 32'hC, NOP, 1'b1, 32'hC);

      // Redirect while waiting; stale response arrives two cycles later
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
      expect_out("rdw", 1'b0, 32'hC, NOP, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("drop1", 1'b0, 32'h100, NOP, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      expect_out("drop2", 1'b0, 32'h100, NOP, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("r100", 1'b0, 32'h100, NOP, 1'b1, 32'h100);

      // Redirect coincident with the response
      drive(1'b0, 1'b1, 32'h2222_0100, 1'b0, 1'b1, 32'h200);
      expect_out("rdrsp", 1'b0, 32'h100, NOP, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("r200", 1'b0, 32'h200, NOP, 1'b1, 32'h200);

      // Redirect during HOLD with stall, misaligned target
      drive(1'b0, 1'b1, 32'h3333_0200, 1'b1, 1'b0, 32'h0);
      check_val("h0.reqv", {31'd0, imem_bus.imem_req_valid}, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      expect_out("hold", 1'b1, 32'h200, 32'h3333_0200, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
      expect_out("rdhold", 1'b0, 32'h200, NOP, 1'b0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("al0", 1'b0, 32'h100, NOP, 1'b1, 32'h100);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("al1", 1'b0, 32'h100, NOP, 1'b1, 32'h100);
      drive(1'b0, 1'b1, 32'h4444_0100, 1'b0, 1'b0, 32'h0);
      expect_out("f100", 1'b1, 32'h100, 32'h4444_0100, 1'b0, 32'h0);

      // Redirect from REQ to the top word, then wrap to 0
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      expect_out("rdreq", 1'b0, 32'h104, NOP, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("topq", 1'b0, 32'hFFFF_FFFC, NOP, 1'b1, 32'hFFFF_FFFC);
      drive(1'b0, 1'b1, 32'h5555_FFFC, 1'b0, 1'b0, 32'h0);
      expect_out("topr", 1'b1, 32'hFFFF_FFFC, 32'h5555_FFFC, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("wrapq", 1'b0, 32'h0, NOP, 1'b1, 32'h0);
      drive(1'b0, 1'b1, 32'h6666_0000, 1'b0, 1'b0, 32'h0);
      expect_out("wrapr", 1'b1, 32'h0, 32'h6666_0000, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      expect_out("f4bq", 1'b0, 32'h4, NOP, 1'b1, 32'h4);

      // Reset asserted mid-WAIT with a response on the bus
      @(posedge clk);
      #1;
      rst                      = 1'b0;
      imem_bus.imem_req_ready  = 1'b0;
      imem_bus.imem_resp_valid = 1'b1;
      imem_bus.imem_resp_data  = 32'h7777_0004;
      #1;
      expect_out("midrst", 1'b0, 32'h0, NOP, 1'b0, 32'h0);

      @(posedge clk);
      #1;
      rst                      = 1'b1;
      imem_bus.imem_resp_valid = 1'b0;
      #1;
      expect_out("rel2", 1'b0, 32'h0, NOP, 1'b1, 32'h0);

      // 25 post-reset cycles: 5 idle request cycles, then 10 fetches
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         check_val("idle.addr", imem_bus.imem_req_addr, 32'h0);
      end
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         check_val("seq.addr", imem_bus.imem_req_addr, 32'(i * 4));
         drive(1'b0, 1'b1, 32'h7000_0000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
         check_val("seq.pc", pc_out, 32'(i * 4));
         check_val("seq.instr", instr_out, 32'h7000_0000 + 32'(i * 4));
      end
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_val("end.addr", imem_bus.imem_req_addr, 32'h28);
`ifdef IF_PERF_CNT_EN
      check_val("perf.fetch", perf_fetch_cnt, 32'd10);
      check_val("perf.bubble", perf_bubble_cnt, 32'd15);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC, issues single-outstanding requests to instruction memory over a valid/ready handshake, and presents {pc, instr, valid} to IF/ID. It absorbs hazard-unit stalls by buffering a returned instruction. It honours branch/jump redirects from EX by discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction driven on instr_out whenever valid_out=0 (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hazard unit; 1 = IF/ID not accepting this cycle (same signal as IF/ID en inverted).
redirect_valid  in  1  EX taken branch/jump this cycle.
redirect_pc  in  32  redirect target.
imem_req_valid  out  1  request to instruction memory.
imem_req_addr  out  32  request address (word aligned).
imem_req_ready  in  1  memory accepts request.
imem_resp_valid  in  1  response data valid (arrives ≥1 cycle after acceptance).
imem_resp_data  in  32  fetched instruction.
pc_out  out  32  PC of presented instruction, to IF/ID pc_in.
instr_out  out  32  presented instruction, to IF/ID instr_in.
valid_out  out  1  pc_out/instr_out hold a real instruction.

Behaviour:
- Reset (rst=0, async): pc_q=RESET_PC, state=REQ, hold buffer cleared. Outputs: valid_out=0, instr_out=NOP_INSTR, pc_out=0, imem_req_valid=0 during reset.
- Max one outstanding request. States: REQ, WAIT, HOLD, DROP.
- REQ: imem_req_valid=1, imem_req_addr=pc_q. On imem_req_ready → WAIT. Address stays stable until accepted.
- WAIT, resp_valid, stall=0: combinational pass-through: valid_out=1, instr_out=resp_data, pc_out=pc_q. Next: pc_q+=4, → REQ. Fetch-to-present latency is 0 cycles after resp_valid; throughput is 1 instr per 2 cycles minimum.
- WAIT, resp_valid, stall=1: capture resp_data into hold buffer → HOLD.
- HOLD: valid_out=1, instr_out=buffer, pc_out=pc_q. Once stall=0 (instruction consumed that cycle): pc_q+=4, → REQ.
- Redirect priority over stall and over all state activity:
  - In the redirect cycle, valid_out=0 and imem_req_valid=0.
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - REQ → REQ.
  - HOLD → REQ, buffer discarded.
  - WAIT with resp_valid same cycle → REQ, data discarded.
  - WAIT without resp_valid → DROP.
  - DROP → DROP (pc_q updated).
- DROP: valid_out=0. On resp_valid, discard the data, → REQ.
- pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- valid_out=0 ⇒ instr_out=NOP_INSTR and pc_out=pc_q.
- The downstream flush input is driven by the top level from redirect_valid; this block does not generate it.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0], both reset to 0 and wrapping.
- perf_fetch_cnt increments on each cycle with valid_out=1 and stall=0.
- perf_bubble_cnt increments on each cycle with valid_out=0 and rst=1.
When undefined, the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
Shared package: state enum (REQ/WAIT/HOLD/DROP), NOP_INSTR constant, default RESET_PC, PC increment constant 4. One sub-module, if_hold_buffer: a 32-bit enable-loaded register with async active-low clear, used for the stalled instruction.

Test Plan:
- Reset release, memory ready=1, 1-cycle response latency, stall=0: pc_out sequence 0,4,8,12 with matching instr, valid_out every 2nd cycle.
- Response at pc 8 while stall=1 for 3 cycles: valid_out=1, instr held 3 cycles; no new imem request until stall drops; next request addr=12.
- Redirect to 0x100 while in WAIT (response 2 cycles later): that response discarded, valid_out=0; next request addr=0x100.
- Redirect coincident with resp_valid, and redirect during HOLD with stall=1: no instruction presented; next request addr=redirect target; redirect_pc=0x103 → request 0x100.
- pc_q=32'hFFFF_FFFC fetch completes: next request addr=0; rst asserted mid-WAIT → outputs return to reset values immediately; after release, first request addr=RESET_PC.
- With IF_PERF_CNT_EN: 10 instructions over 25 post-reset cycles → perf_fetch_cnt=10, perf_bubble_cnt=15.
